// File: rtl/fir_sample_player_if.sv
// Control, buffer-load and sample-stream signals of the FIR sample player.
// The master side drives controls and consumes samples; the player is the slave.
interface fir_sample_player_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEPTH        = 1024,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int DIV_WIDTH    = 8,
  parameter int WRAP_WIDTH   = 16
);
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [SAMPLE_WIDTH-1:0] wr_data;
  logic                    start;
  logic                    stop;
  logic                    loop_mode;
  logic [ADDR_WIDTH:0]     play_len;
  logic [DIV_WIDTH-1:0]    rate_div;
  logic [SAMPLE_WIDTH-1:0] sample_out;
  logic                    sample_valid;
  logic                    sample_ready;
  logic                    busy;
  logic                    done;
  logic [WRAP_WIDTH-1:0]   wrap_count;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop_mode, play_len, rate_div,
           sample_ready,
    input  sample_out, sample_valid, busy, done, wrap_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop_mode, play_len, rate_div,
           sample_ready,
    output sample_out, sample_valid, busy, done, wrap_count
  );
endinterface

// File: rtl/fir_sample_player.sv
// Replays a write-loadable sample buffer as a paced valid/ready stream,
// one-shot or looping, with abort. The output register doubles as the RAM read register.
module fir_sample_player #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEPTH        = 1024,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int DIV_WIDTH    = 8,
  parameter int WRAP_WIDTH   = 16
) (
  input logic                CLK,
  input logic                rst,
  fir_sample_player_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_LEN = (ADDR_WIDTH+1)'(DEPTH);

  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [ADDR_WIDTH-1:0]   last_addr_reg;
  logic [DIV_WIDTH-1:0]    pace_reg;
  logic [DIV_WIDTH-1:0]    div_reg;
  logic                    loop_reg;
  logic                    abort_reg;
  logic [SAMPLE_WIDTH-1:0] sample_reg;
  logic                    valid_reg;
  logic                    done_reg;
  logic [WRAP_WIDTH-1:0]   wrap_reg;

  logic [ADDR_WIDTH:0]     eff_len;
  logic [ADDR_WIDTH:0]     eff_len_m1;
  logic                    slot_free;
  logic                    handshake;
  logic                    issue;

  always_comb begin
    eff_len    = (bus.play_len > DEPTH_LEN) ? DEPTH_LEN : bus.play_len;
    eff_len_m1 = eff_len - (ADDR_WIDTH+1)'(1);
    handshake  = valid_reg & bus.sample_ready;
    slot_free  = ~valid_reg | bus.sample_ready;
    // stop wins over an issue in the same cycle
    issue      = (state_reg == PLAY) & ~bus.stop & (pace_reg == div_reg) & slot_free;
  end

  // Buffer write port: no reset, contents survive rst.
  always_ff @(posedge CLK) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      last_addr_reg <= '0;
      pace_reg      <= '0;
      div_reg       <= '0;
      loop_reg      <= 1'b0;
      abort_reg     <= 1'b0;
      sample_reg    <= '0;
      valid_reg     <= 1'b0;
      done_reg      <= 1'b0;
      wrap_reg      <= '0;
    end else begin
      done_reg <= 1'b0;

      if (issue) begin
        sample_reg <= mem[addr_reg];
        valid_reg  <= 1'b1;
      end else if (handshake) begin
        valid_reg  <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (bus.start && (bus.play_len != '0)) begin
            state_reg     <= PLAY;
            loop_reg      <= bus.loop_mode;
            div_reg       <= bus.rate_div;
            last_addr_reg <= eff_len_m1[ADDR_WIDTH-1:0];
            addr_reg      <= '0;
            pace_reg      <= '0;
            wrap_reg      <= '0;
            abort_reg     <= 1'b0;
          end
        end
        PLAY: begin
          if (bus.stop) begin
            state_reg <= DRAIN;
            abort_reg <= 1'b1;
          end else if (issue) begin
            pace_reg <= '0;
            if (addr_reg == last_addr_reg) begin
              addr_reg <= '0;
              if (loop_reg) begin
                if (~&wrap_reg) begin
                  wrap_reg <= wrap_reg + WRAP_WIDTH'(1);
                end
              end else begin
                state_reg <= DRAIN;
              end
            end else begin
              addr_reg <= addr_reg + ADDR_WIDTH'(1);
            end
          end else if (pace_reg != div_reg) begin
            // pace saturates so backpressure just delays the next issue
            pace_reg <= pace_reg + DIV_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (bus.stop) begin
            abort_reg <= 1'b1;
          end
          if (!valid_reg || handshake) begin
            state_reg <= IDLE;
            done_reg  <= ~abort_reg & ~bus.stop;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.sample_out   = sample_reg;
  assign bus.sample_valid = valid_reg;
  assign bus.busy         = (state_reg != IDLE);
  assign bus.done         = done_reg;
  assign bus.wrap_count   = wrap_reg;
endmodule

// File: tb/tb_fir_sample_player.sv
// Directed bench for fir_sample_player: one task per scenario with inline checks.
module tb_fir_sample_player;
  localparam int SW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int DW    = 8;
  localparam int WW    = 16;

  logic CLK = 1'b0;
  logic rst;
  always #5 CLK = ~CLK;

  fir_sample_player_if #(.SAMPLE_WIDTH(SW), .DEPTH(DEPTH), .DIV_WIDTH(DW), .WRAP_WIDTH(WW)) bus ();

  fir_sample_player #(.SAMPLE_WIDTH(SW), .DEPTH(DEPTH), .DIV_WIDTH(DW), .WRAP_WIDTH(WW)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [SW-1:0] hs_val[$];
  int            hs_k[$];
  int            done_n;
  int            done_k;
  int            hold_bad;
  bit            timed_out;

  // All tasks start and end at a point 1ns after a rising edge.
  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic load(input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_data = SW'(data);
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic start_play(input int len, input bit loop_m, input int div);
    bus.play_len  = (AW+1)'(len);
    bus.loop_mode = loop_m;
    bus.rate_div  = DW'(div);
    bus.start     = 1'b1;
    step();
    bus.start     = 1'b0;
  endtask

  // Records handshakes until the player goes idle; optionally stalls ready
  // for stall_len cycles once stall_after samples have been accepted.
  task automatic capture(input int max_k, input int stall_after, input int stall_len);
    int left;
    bit stalled;
    bit stall_now;
    logic [SW-1:0] held;
    hs_val.delete();
    hs_k.delete();
    done_n = 0; done_k = 0; hold_bad = 0; timed_out = 1'b1;
    left = 0; stalled = 1'b0; held = '0;
    for (int k = 1; k <= max_k; k++) begin
      if (bus.done) begin
        done_n++;
        done_k = k;
      end
      if (!bus.busy) begin
        timed_out = 1'b0;
        break;
      end
      stall_now = 1'b0;
      if (!stalled && stall_len > 0 && bus.sample_valid && hs_val.size() == stall_after) begin
        stalled = 1'b1;
        held    = bus.sample_out;
        left    = stall_len;
      end
      if (left > 0) begin
        if (!bus.sample_valid || bus.sample_out !== held) hold_bad++;
        left--;
        stall_now = 1'b1;
      end
      bus.sample_ready = !stall_now;
      if (bus.sample_valid && bus.sample_ready) begin
        hs_val.push_back(bus.sample_out);
        hs_k.push_back(k);
      end
      step();
    end
    bus.sample_ready = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.sample_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got valid=%b busy=%b done=%b exp 0 0 0",
               bus.sample_valid, bus.busy, bus.done);
    end
    checks++;
    if (bus.sample_out !== '0 || bus.wrap_count !== '0) begin
      errors++;
      $display("FAIL reset_data got out=%h wrap=%0d exp 0 0", bus.sample_out, bus.wrap_count);
    end
  endtask

  task automatic test_one_shot();
    for (int i = 0; i < 8; i++) load(i, i + 1);
    bus.sample_ready = 1'b1;
    start_play(8, 1'b0, 0);
    capture(60, -1, 0);
    checks++;
    if (timed_out || hs_val.size() != 8) begin
      errors++;
      $display("FAIL one_shot_count got %0d exp 8 (timeout=%0d)", hs_val.size(), timed_out);
    end
    for (int i = 0; i < hs_val.size() && i < 8; i++) begin
      checks++;
      if (hs_val[i] !== SW'(i + 1) || hs_k[i] != i + 2) begin
        errors++;
        $display("FAIL one_shot_sample[%0d] got %h@%0d exp %h@%0d", i, hs_val[i], hs_k[i], i + 1, i + 2);
      end
    end
    checks++;
    if (done_n != 1 || done_k != 10) begin
      errors++;
      $display("FAIL one_shot_done got count=%0d at=%0d exp 1 at 10", done_n, done_k);
    end
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL one_shot_after got done=%b busy=%b exp 0 0", bus.done, bus.busy);
    end
    $display("one_shot: %0d samples, done_count=%0d", hs_val.size(), done_n);
  endtask

  task automatic test_rate();
    start_play(8, 1'b0, 3);
    capture(80, -1, 0);
    checks++;
    if (timed_out || hs_val.size() != 8) begin
      errors++;
      $display("FAIL rate_count got %0d exp 8 (timeout=%0d)", hs_val.size(), timed_out);
    end
    for (int i = 1; i < hs_val.size(); i++) begin
      checks++;
      if (hs_k[i] - hs_k[i-1] != 4 || hs_val[i] !== SW'(i + 1)) begin
        errors++;
        $display("FAIL rate_spacing[%0d] got gap=%0d val=%h exp gap=4 val=%h",
                 i, hs_k[i] - hs_k[i-1], hs_val[i], i + 1);
      end
    end
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL rate_done got %0d exp 1", done_n);
    end
    $display("rate: %0d samples, done_count=%0d", hs_val.size(), done_n);
  endtask

  task automatic test_backpressure();
    start_play(8, 1'b0, 0);
    capture(60, 2, 5);
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL bp_hold got %0d unstable cycles exp 0", hold_bad);
    end
    checks++;
    if (timed_out || hs_val.size() != 8) begin
      errors++;
      $display("FAIL bp_count got %0d exp 8 (timeout=%0d)", hs_val.size(), timed_out);
    end
    for (int i = 0; i < hs_val.size() && i < 8; i++) begin
      checks++;
      if (hs_val[i] !== SW'(i + 1)) begin
        errors++;
        $display("FAIL bp_sample[%0d] got %h exp %h", i, hs_val[i], i + 1);
      end
    end
    checks++;
    if (hs_val.size() >= 3 && hs_k[2] != 9) begin
      errors++;
      $display("FAIL bp_resume got sample3@%0d exp 9", hs_k[2]);
    end
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL bp_done got %0d exp 1", done_n);
    end
    $display("backpressure: %0d samples, hold_bad=%0d", hs_val.size(), hold_bad);
  endtask

  task automatic test_loop_stop();
    int hs = 0;
    int k  = 0;
    int dn = 0;
    bus.sample_ready = 1'b1;
    start_play(4, 1'b1, 0);
    while (hs < 10 && k < 100) begin
      if (bus.done) dn++;
      if (bus.sample_valid) begin
        checks++;
        if (bus.sample_out !== SW'((hs % 4) + 1)) begin
          errors++;
          $display("FAIL loop_seq[%0d] got %h exp %h", hs, bus.sample_out, (hs % 4) + 1);
        end
        hs++;
      end
      step();
      k++;
    end
    checks++;
    if (hs != 10) begin
      errors++;
      $display("FAIL loop_timeout got %0d handshakes exp 10", hs);
    end
    checks++;
    if (bus.wrap_count !== WW'(2)) begin
      errors++;
      $display("FAIL loop_wrap got %0d exp 2", bus.wrap_count);
    end
    bus.stop = 1'b1;
    bus.sample_ready = 1'b0;
    step();
    bus.stop = 1'b0;
    if (bus.done) dn++;
    checks++;
    if (bus.busy !== 1'b1 || bus.sample_valid !== 1'b1 || bus.sample_out !== SW'(3)) begin
      errors++;
      $display("FAIL loop_pending got busy=%b valid=%b out=%h exp 1 1 0003",
               bus.busy, bus.sample_valid, bus.sample_out);
    end
    bus.sample_ready = 1'b1;
    step();
    if (bus.done) dn++;
    checks++;
    if (bus.busy !== 1'b0 || bus.sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop_idle got busy=%b valid=%b exp 0 0", bus.busy, bus.sample_valid);
    end
    repeat (3) begin
      step();
      if (bus.done) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL loop_done got %0d pulses exp 0", dn);
    end
    checks++;
    if (bus.wrap_count !== WW'(2)) begin
      errors++;
      $display("FAIL loop_wrap_hold got %0d exp 2", bus.wrap_count);
    end
    $display("loop_stop: %0d handshakes, wrap=%0d, done_pulses=%0d", hs, bus.wrap_count, dn);
  endtask

  task automatic test_async_reset();
    bus.sample_ready = 1'b1;
    start_play(8, 1'b0, 0);
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.sample_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sample_out !== '0) begin
      errors++;
      $display("FAIL async_reset got valid=%b busy=%b out=%h exp 0 0 0000",
               bus.sample_valid, bus.busy, bus.sample_out);
    end
    #2;
    rst = 1'b0;
    step();
    start_play(8, 1'b0, 0);
    capture(60, -1, 0);
    checks++;
    if (timed_out || hs_val.size() != 8) begin
      errors++;
      $display("FAIL reset_replay_count got %0d exp 8", hs_val.size());
    end
    for (int i = 0; i < hs_val.size() && i < 8; i++) begin
      checks++;
      if (hs_val[i] !== SW'(i + 1)) begin
        errors++;
        $display("FAIL reset_replay[%0d] got %h exp %h", i, hs_val[i], i + 1);
      end
    end
    $display("async_reset: replay %0d samples", hs_val.size());
  endtask

  task automatic test_zero_len();
    start_play(0, 1'b0, 0);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_busy got %b exp 0", bus.busy);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_idle got busy=%b valid=%b exp 0 0", bus.busy, bus.sample_valid);
    end
    $display("zero_len: busy=%b", bus.busy);
  endtask

  task automatic test_over_len();
    for (int i = 0; i < DEPTH; i++) load(i, 16'h0100 + i);
    start_play(DEPTH + 5, 1'b0, 0);
    capture(100, -1, 0);
    checks++;
    if (timed_out || hs_val.size() != DEPTH) begin
      errors++;
      $display("FAIL over_len_count got %0d exp %0d", hs_val.size(), DEPTH);
    end
    for (int i = 0; i < hs_val.size() && i < DEPTH; i++) begin
      checks++;
      if (hs_val[i] !== SW'(16'h0100 + i)) begin
        errors++;
        $display("FAIL over_len[%0d] got %h exp %h", i, hs_val[i], 16'h0100 + i);
      end
    end
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL over_len_done got %0d exp 1", done_n);
    end
    $display("over_len: %0d samples, done_count=%0d", hs_val.size(), done_n);
  endtask

  task automatic test_same_addr();
    int k = 0;
    bus.sample_ready = 1'b1;
    start_play(4, 1'b0, 0);
    step();
    step();
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(2);
    bus.wr_data = 16'hBEEF;
    step();
    bus.wr_en   = 1'b0;
    checks++;
    if (bus.sample_valid !== 1'b1 || bus.sample_out !== 16'h0102) begin
      errors++;
      $display("FAIL same_addr_old got valid=%b out=%h exp 1 0102", bus.sample_valid, bus.sample_out);
    end
    while (bus.busy && k < 20) begin
      step();
      k++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL same_addr_timeout got busy=%b exp 0", bus.busy);
    end
    start_play(4, 1'b0, 0);
    capture(40, -1, 0);
    checks++;
    if (hs_val.size() != 4 || hs_val[2] !== 16'hBEEF) begin
      errors++;
      $display("FAIL same_addr_new got n=%0d val=%h exp 4 BEEF", hs_val.size(),
               (hs_val.size() > 2) ? hs_val[2] : 16'h0);
    end
    $display("same_addr: write landed, replay count=%0d", hs_val.size());
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_mode = 1'b0;
    bus.play_len = '0; bus.rate_div = '0; bus.sample_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b0;
    step();

    test_reset();
    test_one_shot();
    test_rate();
    test_backpressure();
    test_loop_stop();
    test_async_reset();
    test_zero_len();
    test_over_len();
    test_same_addr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_sample_player.md
Name: fir_sample_player

Overview:
Synthesizable, parametrised sample-stream source that replays a loaded buffer into the FIR datapath. It generalises the fixed-length looping stimulus feed with several additions: a write-loadable buffer, programmable length, one-shot or loop mode, rate pacing, a valid/ready output handshake with backpressure, and a stop/abort control. It sits upstream of the FIR sample_in port, for on-chip self-test and for lab bring-up.

Parameters:
SAMPLE_WIDTH, 16, bits per sample.
DEPTH, 1024, buffer entries.
ADDR_WIDTH, $clog2(DEPTH), buffer address width (derived; do not override).
DIV_WIDTH, 8, width of the rate divider.
WRAP_WIDTH, 16, width of the loop-pass counter.

Ports:
CLK  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
wr_en  in  1  buffer write strobe.
wr_addr  in  ADDR_WIDTH  buffer write address.
wr_data  in  SAMPLE_WIDTH  buffer write data.
start  in  1  start playback (level sampled each cycle).
stop  in  1  abort playback.
loop_mode  in  1  1 = loop forever, 0 = one-shot.
play_len  in  ADDR_WIDTH+1  number of samples per pass.
rate_div  in  DIV_WIDTH  issue interval minus 1.
sample_out  out  SAMPLE_WIDTH  current sample.
sample_valid  out  1  sample_out holds a valid sample.
sample_ready  in  1  downstream accepts the sample.
busy  out  1  FSM is not IDLE.
done  out  1  one-cycle pulse at one-shot completion.
wrap_count  out  WRAP_WIDTH  completed loop passes, saturating.

Behaviour:
- Reset (async, immediate): state IDLE; sample_out=0, sample_valid=0, busy=0, done=0, wrap_count=0; read address and pace counter cleared. Buffer contents are not reset and are retained.
- Buffer: synchronous write on wr_en, allowed in any state. Synchronous read with 1-cycle latency. Read and write to the same address in the same cycle returns the old data.
- FSM states: IDLE, PLAY, DRAIN.
- IDLE -> PLAY on start=1 with play_len!=0. On this transition:
  - latch loop_mode, rate_div, and the effective length L = min(play_len, DEPTH);
  - addr=0, pace counter=0, wrap_count=0.
- start with play_len=0 is ignored. start while busy is ignored.
- Issue rule in PLAY: a read of addr is issued when both of these hold:
  - pace counter == latched rate_div;
  - the output slot is free (sample_valid=0, or sample_valid & sample_ready this cycle).
- On issue:
  - pace counter resets to 0; otherwise it increments and saturates at rate_div (it stalls under backpressure);
  - the first issue occurs the cycle after start;
  - sample_out is loaded and sample_valid=1 on the cycle after issue;
  - sample_valid drops on a handshake unless a new issue lands the same cycle.
- Throughput: with rate_div=0 and sample_ready=1, one sample per cycle. With rate_div=N, valid samples are spaced N+1 cycles apart.
- sample_out must stay stable while sample_valid=1 and sample_ready=0.
- Issuing address L-1:
  - loop_mode=1: addr wraps to 0 and wrap_count increments, saturating at all-ones.
  - loop_mode=0: FSM -> DRAIN.
- DRAIN: no further issues. When the final sample handshakes (or if none is pending), done=1 for exactly one cycle and FSM -> IDLE.
- stop=1 in PLAY:
  - stop overrides an issue in the same cycle; FSM -> DRAIN with the abort flag set;
  - the pending valid sample is still delivered;
  - on exit to IDLE, done stays 0.
- stop in IDLE or DRAIN: no effect, except that stop in DRAIN sets the abort flag and suppresses done.
- busy = (state != IDLE).
- wrap_count holds its value in IDLE until the next start.

Test Plan:
- Load buffer[0..7]=16'h0001..16'h0008; play_len=8, loop_mode=0, rate_div=0, ready=1; pulse start -> sample_valid high for 8 consecutive cycles beginning 2 cycles after start, outputs 1..8 in order, done pulses once the cycle after the last handshake, busy then falls.
- Same load with rate_div=3 -> valid samples spaced exactly 4 cycles apart, 8 samples total, done pulses once.
- rate_div=0; hold sample_ready=0 for 5 cycles after the 3rd sample appears -> sample_out holds 16'h0003 for all 5 cycles, no sample lost or duplicated, stream resumes 4,5,...
- loop_mode=1, play_len=4; run 10 handshakes -> sequence 1,2,3,4,1,2,3,4,1,2 and wrap_count=2. Assert stop -> the pending sample is delivered, busy falls, and done never pulses.
- Assert rst mid-play -> sample_valid, busy and sample_out are 0 immediately (asynchronously). A fresh start then replays from 16'h0001, proving the buffer was retained.
- Boundaries: start with play_len=0 -> busy stays 0. play_len=DEPTH+5 in one-shot mode -> exactly DEPTH samples, then done. A write to address 2 in the same cycle as its read issue -> old value output.
